// File: rtl/encoder4to2_arb_pkg.sv
// Shared types and helpers for the 4-to-2 request encoder/arbiter.
// Request count, index width, FSM state type and the index-to-mask helper.
package encoder_pkg;

   localparam int N_REQ = 4;
   localparam int IDX_W = 2;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   // One-hot mask with only the bit for idx set.
   function automatic logic [N_REQ-1:0] idx_to_mask(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] mask;
      mask      = '0;
      mask[idx] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/encoder4to2_arb_if.sv
// Valid/ready handshake carrying the encoded index {A,B}.
// The encoder drives valid/A/B through the master modport.
// The consumer drives ready through the slave modport.
interface encoder4to2_arb_if;

   logic valid;
   logic ready;
   logic A;
   logic B;

   modport master (output valid, output A, output B, input ready);
   modport slave  (input valid, input A, input B, output ready);

endinterface

// File: rtl/encoder4to2_arb_prio_pick.sv
// Combinational selector that picks one index from the pending vector.
// With ENC_ROUND_ROBIN_EN defined, the search starts at ptr+1 and wraps from 3 to 0.
// Without the macro, selection is fixed priority with index 3 highest, and ptr is ignored.
module prio_pick
   import encoder_pkg::*;
(
   input  logic [N_REQ-1:0] pend,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] idx
);

   assign any = |pend;

`ifdef ENC_ROUND_ROBIN_EN
   // Walk the offsets from farthest to nearest so the nearest candidate after ptr wins.
   // An offset of N_REQ wraps back onto ptr itself, which makes ptr the last choice.
   always_comb begin
      idx = '0;
      for (int off = N_REQ; off >= 1; off--) begin
         if (pend[ptr + IDX_W'(off)]) idx = ptr + IDX_W'(off);
      end
   end
`else
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   // Ascending scan, so the highest set index is the one that remains.
   always_comb begin
      idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pend[i]) idx = IDX_W'(i);
      end
   end
`endif

endmodule

// File: rtl/encoder4to2_arb.sv
// Sequential 4-to-2 encoder with arbitration.
// Request lines Y3..Y0 collect into a pending register. Each pending request is then
// emitted as an index {A,B} over a valid/ready handshake, one index per accepted cycle.
// Define ENC_ROUND_ROBIN_EN for round-robin selection. The default build uses fixed priority.
module encoder4to2_arb
   import encoder_pkg::*;
#(
   parameter logic [IDX_W-1:0] PTR_INIT = 2'b11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              Y3,
   input  logic              Y2,
   input  logic              Y1,
   input  logic              Y0,
   encoder4to2_arb_if.master bus,
   output logic [N_REQ-1:0]  pend,
   output logic              ovf
);

   state_t           state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   logic             take;
   logic             grant;
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] grant_mask;
   logic [N_REQ-1:0] pend_next;
   logic             ovf_hit;

   prio_pick u_pick (
      .pend (pend),
      .ptr  (ptr),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   // Work out this cycle's grant and the next pending set, using only registered pend.
   always_comb begin
      // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
      req        = en ? {Y3, Y2, Y1, Y0} : '0;
      take       = (state == IDLE) || bus.ready;
      grant      = take && pick_any;
      grant_mask = grant ? idx_to_mask(pick_idx) : '0;
      // A bit that is granted and re-requested in the same cycle stays set as a fresh request.
      pend_next  = (pend & ~grant_mask) | req;
      ovf_hit    = |(req & pend & ~grant_mask);
   end

   // Pending/overflow/pointer registers plus the handshake FSM and its registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pend      <= '0;
         ovf       <= 1'b0;
         ptr       <= PTR_INIT;
         bus.valid <= 1'b0;
         bus.A     <= 1'b0;
         bus.B     <= 1'b0;
      end else begin
         // NOTE: use non-blocking assignments here, so every register samples pre-edge values.
         pend <= pend_next;
         if (ovf_hit) ovf <= 1'b1;
         case (state)
            IDLE: begin
               if (grant) begin
                  {bus.A, bus.B} <= pick_idx;
                  bus.valid      <= 1'b1;
                  ptr            <= pick_idx;
                  state          <= HOLD;
               end
            end
            HOLD: begin
               if (bus.ready) begin
                  if (grant) begin
                     {bus.A, bus.B} <= pick_idx;
                     ptr            <= pick_idx;
                  end else begin
                     bus.valid <= 1'b0;
                     state     <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_encoder4to2_arb.sv
// Self-checking bench for encoder4to2_arb.
// Directed scenarios compare the outputs against tabulated expectations.
// A randomized phase compares the outputs against a behavioural model of the request queue.
// The bench follows ENC_ROUND_ROBIN_EN the same way the design does.
`timescale 1ns/1ps
module tb_encoder4to2_arb;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       en    = 1'b0;
   logic [3:0] y     = 4'b0000;
   logic [3:0] pend;
   logic       ovf;
   logic [7:0] obs;
   int         n_checks = 0;
   int         n_fail   = 0;

   encoder4to2_arb_if bus ();

   encoder4to2_arb #(.PTR_INIT(2'b11)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .Y3    (y[3]),
      .Y2    (y[2]),
      .Y1    (y[1]),
      .Y0    (y[0]),
      .bus   (bus),
      .pend  (pend),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   // Observation word: {valid, A, B, pend[3:0], ovf}
   assign obs = {bus.valid, bus.A, bus.B, pend, ovf};

   task automatic drive(input logic e, input logic [3:0] yv, input logic r);
      en        = e;
      y         = yv;
      bus.ready = r;
   endtask

   // Advance past one rising edge and settle 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      drive(1'b0, 4'b0000, 1'b0);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   // ---------------- reference model ----------------
   logic [3:0] m_pend;
   logic       m_valid;
   logic [1:0] m_idx;
   logic       m_ovf;
   int         m_ptr;

   function automatic int model_pick(input logic [3:0] p, input int ptr);
`ifdef ENC_ROUND_ROBIN_EN
      for (int off = 1; off <= 4; off++) begin
         if (p[(ptr + off) % 4]) return (ptr + off) % 4;
      end
`else
      for (int i = 3; i >= 0; i--) begin
         if (p[i]) return i;
      end
`endif
      return -1;
   endfunction

   task automatic model_reset();
      m_pend  = 4'b0000;
      m_valid = 1'b0;
      m_idx   = 2'b00;
      m_ovf   = 1'b0;
      m_ptr   = 3;
   endtask

   // Model one clock edge: while nothing is on offer, or the offer is taken, the next request is picked.
   task automatic model_edge(input logic e, input logic [3:0] yv, input logic r);
      logic [3:0] gm;
      logic [3:0] newreq;
      int         k;
      gm = 4'b0000;
      if (!m_valid || r) begin
         k = model_pick(m_pend, m_ptr);
         if (k >= 0) begin
            m_idx   = 2'(k);
            m_valid = 1'b1;
            gm[k]   = 1'b1;
            m_ptr   = k;
         end else begin
            m_valid = 1'b0;
         end
      end
      newreq = e ? yv : 4'b0000;
      if ((newreq & m_pend & ~gm) != 4'b0000) m_ovf = 1'b1;
      m_pend = (m_pend & ~gm) | newreq;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [13:0] tbl [5];
      // Row: {en, Y[3:0], ready, expected {valid,A,B,pend,ovf}}
`ifdef ENC_ROUND_ROBIN_EN
      tbl = '{ {1'b1, 4'b0101, 1'b1, 8'b0_00_0101_0},
               {1'b0, 4'b0101, 1'b1, 8'b1_00_0100_0},
               {1'b0, 4'b0101, 1'b1, 8'b1_10_0000_0},
               {1'b0, 4'b0101, 1'b1, 8'b0_10_0000_0},
               {1'b0, 4'b0101, 1'b1, 8'b0_10_0000_0} };
`else
      tbl = '{ {1'b1, 4'b0101, 1'b1, 8'b0_00_0101_0},
               {1'b0, 4'b0101, 1'b1, 8'b1_10_0001_0},
               {1'b0, 4'b0101, 1'b1, 8'b1_00_0000_0},
               {1'b0, 4'b0101, 1'b1, 8'b0_00_0000_0},
               {1'b0, 4'b0101, 1'b1, 8'b0_00_0000_0} };
`endif
      drive(1'b0, 4'b0101, 1'b1);
      #1 rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (obs !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_hold[%0d]: got %b expected %b", i, obs, 8'h00);
         end
      end
      rst_n = 1'b1;
      foreach (tbl[i]) begin
         drive(tbl[i][13], tbl[i][12:9], tbl[i][8]);
         tick();
         n_checks++;
         if (obs !== tbl[i][7:0]) begin
            n_fail++;
            $display("FAIL reset_first[%0d]: got %b expected %b", i, obs, tbl[i][7:0]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [13:0] tbl [8];
      tbl = '{ {1'b1, 4'b0010, 1'b0, 8'b0_00_0010_0},
               {1'b0, 4'b0000, 1'b0, 8'b1_01_0000_0},
               {1'b0, 4'b0000, 1'b0, 8'b1_01_0000_0},
               {1'b0, 4'b0000, 1'b0, 8'b1_01_0000_0},
               {1'b0, 4'b0000, 1'b0, 8'b1_01_0000_0},
               {1'b0, 4'b0000, 1'b0, 8'b1_01_0000_0},
               {1'b0, 4'b0000, 1'b1, 8'b0_01_0000_0},
               {1'b0, 4'b0000, 1'b1, 8'b0_01_0000_0} };
      apply_reset();
      foreach (tbl[i]) begin
         drive(tbl[i][13], tbl[i][12:9], tbl[i][8]);
         tick();
         n_checks++;
         if (obs !== tbl[i][7:0]) begin
            n_fail++;
            $display("FAIL backpressure[%0d]: got %b expected %b", i, obs, tbl[i][7:0]);
         end
      end
   endtask

   task automatic test_overflow();
      logic [13:0] tbl [8];
      tbl = '{ {1'b1, 4'b0001, 1'b0, 8'b0_00_0001_0},
               {1'b0, 4'b0000, 1'b0, 8'b1_00_0000_0},
               {1'b1, 4'b0100, 1'b0, 8'b1_00_0100_0},
               {1'b1, 4'b0100, 1'b0, 8'b1_00_0100_1},
               {1'b0, 4'b0000, 1'b0, 8'b1_00_0100_1},
               {1'b0, 4'b0000, 1'b1, 8'b1_10_0000_1},
               {1'b0, 4'b0000, 1'b1, 8'b0_10_0000_1},
               {1'b0, 4'b0000, 1'b1, 8'b0_10_0000_1} };
      apply_reset();
      foreach (tbl[i]) begin
         drive(tbl[i][13], tbl[i][12:9], tbl[i][8]);
         tick();
         n_checks++;
         if (obs !== tbl[i][7:0]) begin
            n_fail++;
            $display("FAIL overflow[%0d]: got %b expected %b", i, obs, tbl[i][7:0]);
         end
      end
      rst_n = 1'b0;
      #2;
      n_checks++;
      if (ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow_clear: got %b expected %b", ovf, 1'b0);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_regrant();
      logic [13:0] tbl [5];
      tbl = '{ {1'b1, 4'b0001, 1'b0, 8'b0_00_0001_0},
               {1'b1, 4'b0100, 1'b0, 8'b1_00_0100_0},
               {1'b1, 4'b0100, 1'b1, 8'b1_10_0100_0},
               {1'b0, 4'b0000, 1'b1, 8'b1_10_0000_0},
               {1'b0, 4'b0000, 1'b1, 8'b0_10_0000_0} };
      apply_reset();
      foreach (tbl[i]) begin
         drive(tbl[i][13], tbl[i][12:9], tbl[i][8]);
         tick();
         n_checks++;
         if (obs !== tbl[i][7:0]) begin
            n_fail++;
            $display("FAIL regrant[%0d]: got %b expected %b", i, obs, tbl[i][7:0]);
         end
      end
   endtask

   task automatic test_full_load();
      logic [13:0] tbl [10];
`ifdef ENC_ROUND_ROBIN_EN
      tbl = '{ {1'b1, 4'b1111, 1'b1, 8'b0_00_1111_0},
               {1'b0, 4'b0000, 1'b1, 8'b1_00_1110_0},
               {1'b0, 4'b0000, 1'b1, 8'b1_01_1100_0},
               {1'b0, 4'b0000, 1'b1, 8'b1_10_1000_0},
               {1'b0, 4'b0000, 1'b1, 8'b1_11_0000_0},
               {1'b0, 4'b0000, 1'b1, 8'b0_11_0000_0},
               {1'b1, 4'b1001, 1'b1, 8'b0_11_1001_0},
               {1'b0, 4'b0000, 1'b1, 8'b1_00_1000_0},
               {1'b0, 4'b0000, 1'b1, 8'b1_11_0000_0},
               {1'b0, 4'b0000, 1'b1, 8'b0_11_0000_0} };
`else
      tbl = '{ {1'b1, 4'b1111, 1'b1, 8'b0_00_1111_0},
               {1'b0, 4'b0000, 1'b1, 8'b1_11_0111_0},
               {1'b0, 4'b0000, 1'b1, 8'b1_10_0011_0},
               {1'b0, 4'b0000, 1'b1, 8'b1_01_0001_0},
               {1'b0, 4'b0000, 1'b1, 8'b1_00_0000_0},
               {1'b0, 4'b0000, 1'b1, 8'b0_00_0000_0},
               {1'b1, 4'b1001, 1'b1, 8'b0_00_1001_0},
               {1'b0, 4'b0000, 1'b1, 8'b1_11_0001_0},
               {1'b0, 4'b0000, 1'b1, 8'b1_00_0000_0},
               {1'b0, 4'b0000, 1'b1, 8'b0_00_0000_0} };
`endif
      apply_reset();
      foreach (tbl[i]) begin
         drive(tbl[i][13], tbl[i][12:9], tbl[i][8]);
         tick();
         n_checks++;
         if (obs !== tbl[i][7:0]) begin
            n_fail++;
            $display("FAIL full_load[%0d]: got %b expected %b", i, obs, tbl[i][7:0]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [13:0] tbl [3];
      tbl = '{ {1'b1, 4'b0001, 1'b0, 8'b0_00_0001_0},
               {1'b1, 4'b1010, 1'b0, 8'b1_00_1010_0},
               {1'b1, 4'b1010, 1'b0, 8'b1_00_1010_1} };
      apply_reset();
      foreach (tbl[i]) begin
         drive(tbl[i][13], tbl[i][12:9], tbl[i][8]);
         tick();
         n_checks++;
         if (obs !== tbl[i][7:0]) begin
            n_fail++;
            $display("FAIL reset_mid_setup[%0d]: got %b expected %b", i, obs, tbl[i][7:0]);
         end
      end
      // Assert reset between edges. The outputs must clear with no clock edge in between.
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_mid_async: got %b expected %b", obs, 8'h00);
      end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic       e;
      logic       r;
      logic [3:0] yv;
      for (int i = 0; i < 3000; i++) begin
         if (i % 500 == 0) begin
            apply_reset();
            model_reset();
         end
         e  = ($urandom_range(0, 3) != 0);
         yv = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) yv = 4'b0000;
         r  = ($urandom_range(0, 2) != 0);
         drive(e, yv, r);
         tick();
         model_edge(e, yv, r);
         n_checks++;
         if (obs !== {m_valid, m_idx, m_pend, m_ovf}) begin
            n_fail++;
            $display("FAIL random[%0d]: got %b expected %b", i, obs, {m_valid, m_idx, m_pend, m_ovf});
         end
      end
   endtask

   initial begin
      bus.ready = 1'b0;
      test_reset();
      test_backpressure();
      test_overflow();
      test_regrant();
      test_full_load();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
